// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared constants for the bit-serial adder: FSM state encoding and the
//   default operand width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // 2-bit state encoding, kept as plain constants so older tools and
  // waveform scripts that expect fixed codes keep working.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder.sv
// full_adder
//   Combinational 1-bit full adder; the only arithmetic cell in the
//   serial adder datapath.
//   Ports:
//     x, y  : operand bits
//     cin   : carry in
//     s     : sum bit      (x ^ y ^ cin)
//     cout  : carry out    (majority of x, y, cin)
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule : full_adder

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial unsigned adder. On an accepted start the operands and carry-in
//   are captured, then one bit per clock (LSB first) is pushed through a
//   single full adder and a carry flop. The result is registered on the
//   completing edge and held until the next operation completes.
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     start  : request, accepted in IDLE or DONE
//     a, b   : operands, captured on accepted start
//     cin    : carry-in, captured on accepted start
//     busy   : high while bits are being processed
//     done   : one-cycle completion pulse
//     sum    : registered result a+b+cin (low WIDTH bits)
//     cout   : registered carry-out of the MSB
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // A 1-bit counter is still needed when WIDTH=1 so the compare is legal.
  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_acc_next;

  full_adder u_full_adder (
    .x    (r_a[0]),
    .y    (r_b[0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_c)
  );

  // Accumulator shifts right with the new sum bit entering at the MSB, so
  // after WIDTH shifts bit 0 of the result sits at bit 0. Written as shift
  // and OR so it stays legal for WIDTH=1.
  assign w_acc_next = (r_acc >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

  // NOTE: all state below is updated with non-blocking assignments so every
  // flop samples the pre-edge values of the others, exactly like hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        // DONE re-accepts start exactly like IDLE, giving one result every
        // WIDTH+1 cycles when start is held high.
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        // start is deliberately not looked at here: no recapture, no queue.
        ST_RUN: begin
          r_carry <= w_c;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_acc   <= w_acc_next;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_BIT) begin
            // Result registers move only on the completing edge.
            r_sum   <= w_acc_next;
            r_cout  <= w_c;
            r_state <= ST_DONE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Status decoded purely from registered state.
  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Directed and randomized checks of serial_adder at WIDTH=8 and WIDTH=1.
//   Expected results come from plain integer addition a+b+cin; expected
//   timing comes from the documented latency (WIDTH cycles, DONE re-accept).
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;

  // WIDTH=8 instance
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done;
  logic [7:0] sum;
  logic       cout;

  // WIDTH=1 instance
  logic       start1;
  logic [0:0] a1, b1;
  logic       cin1;
  logic       busy1, done1;
  logic [0:0] sum1;
  logic       cout1;

  int n_pass  = 0;
  int n_total = 0;

  // Last completed result of each instance (held-output reference).
  logic [7:0] last_sum  = '0;
  logic       last_cout = 1'b0;
  logic [0:0] last_sum1 = '0;
  logic       last_cout1 = 1'b0;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One WIDTH=8 operation, started at the current negedge. Returns at the
  // negedge where done is (expected to be) high. With glitch set, a start
  // carrying different operands is pulsed mid-run and must be ignored.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tbv, input logic tc,
                     input string tag, input bit glitch);
    logic [8:0] exp;
    int         lat;
    int         busy_n;
    bit         hold_ok;
    exp     = 9'(ta) + 9'(tbv) + 9'(tc);
    a       = ta;
    b       = tbv;
    cin     = tc;
    start   = 1'b1;
    @(negedge clk);
    // Operands need only be stable at the accepting edge.
    start   = 1'b0;
    a       = 8'($urandom);
    b       = 8'($urandom);
    cin     = 1'($urandom);
    lat     = 0;
    busy_n  = 0;
    hold_ok = 1'b1;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      if (sum !== last_sum || cout !== last_cout) hold_ok = 1'b0;
      if (glitch && lat == 3) begin
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        cin   = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'd8);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd8);
    check({tag, "_hold_prev"}, 32'(hold_ok), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_sum"}, 32'(sum), 32'(exp[7:0]));
    check({tag, "_cout"}, 32'(cout), 32'(exp[8]));
    last_sum  = exp[7:0];
    last_cout = exp[8];
  endtask

  // One WIDTH=1 operation; completes after a single RUN cycle.
  task automatic op1(input logic ta, input logic tbv, input logic tc);
    logic [1:0] exp;
    int         lat;
    exp    = 2'(ta) + 2'(tbv) + 2'(tc);
    a1     = ta;
    b1     = tbv;
    cin1   = tc;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    lat    = 0;
    check("w1_busy", 32'(busy1), 32'd1);
    check("w1_hold_prev", 32'({sum1, cout1}), 32'({last_sum1, last_cout1}));
    while (!done1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("w1_latency", 32'(lat), 32'd1);
    check("w1_sum", 32'(sum1), 32'(exp[0]));
    check("w1_cout", 32'(cout1), 32'(exp[1]));
    last_sum1  = exp[0];
    last_cout1 = exp[1];
  endtask

  initial begin
    int done_cyc[$];
    bit stable_ok;
    bit val_ok;
    bit seen;

    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    cin    = 1'b0;
    start1 = 1'b0;
    a1     = '0;
    b1     = '0;
    cin1   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_w1", 32'({busy1, done1, sum1, cout1}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // Basic add, then done must drop after one cycle
    op8(8'h5A, 8'h3C, 1'b0, "add_5a_3c", 1'b0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
    check("sum_held_idle", 32'(sum), 32'h96);

    // Overflow and carry-in only
    op8(8'hFF, 8'h01, 1'b0, "add_ff_01", 1'b0);
    @(negedge clk);
    op8(8'h00, 8'h00, 1'b1, "add_cin_only", 1'b0);
    @(negedge clk);

    // start during RUN must be ignored
    op8(8'h10, 8'h20, 1'b0, "start_in_run", 1'b1);
    @(negedge clk);
    check("start_in_run_no_restart", 32'(busy), 32'd0);

    // start held high: one result every WIDTH+1 cycles
    a         = 8'h80;
    b         = 8'h80;
    cin       = 1'b1;
    start     = 1'b1;
    stable_ok = 1'b1;
    val_ok    = 1'b1;
    seen      = 1'b0;
    for (int cyc = 1; cyc <= 40 && done_cyc.size() < 4; cyc++) begin
      @(negedge clk);
      if (done) begin
        done_cyc.push_back(cyc);
        seen = 1'b1;
        if (sum !== 8'h01 || cout !== 1'b1) val_ok = 1'b0;
      end
      if (seen && (sum !== 8'h01 || cout !== 1'b1)) stable_ok = 1'b0;
    end
    start = 1'b0;
    check("b2b_done_count", 32'(done_cyc.size()), 32'd4);
    if (done_cyc.size() == 4) begin
      check("b2b_first_done", 32'(done_cyc[0]), 32'd9);
      for (int i = 1; i < 4; i++)
        check("b2b_interval", 32'(done_cyc[i] - done_cyc[i-1]), 32'd9);
    end
    check("b2b_values", 32'(val_ok), 32'd1);
    check("b2b_sum_stable", 32'(stable_ok), 32'd1);
    last_sum  = 8'h01;
    last_cout = 1'b1;
    @(negedge clk);
    check("b2b_release_idle", 32'({busy, done}), 32'd0);

    // Asynchronous reset in the middle of an operation
    a     = 8'hAA;
    b     = 8'h55;
    cin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy_before_rst", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_sum", 32'(sum), 32'd0);
    check("async_rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_rst_idle", 32'({busy, done, sum, cout}), 32'd0);
    last_sum  = 8'h00;
    last_cout = 1'b0;
    op8(8'h01, 8'h02, 1'b0, "after_rst_add", 1'b0);
    @(negedge clk);

    // Randomized WIDTH=8; a zero gap restarts straight from DONE
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      op8(8'($urandom), 8'($urandom), 1'($urandom), "rand8", 1'b0);
    end
    @(negedge clk);

    // Randomized WIDTH=1
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      op1(1'($urandom), 1'($urandom), 1'($urandom));
    end
    @(negedge clk);
    check("w1_done_one_cycle", 32'(done1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_serial_adder
